pwm_multi: RTL

Parametrised multi-channel edge-aligned PWM generator. One counter drives every channel. Each channel has a double-buffered duty register, so a duty update takes effect only at a period boundary. Complementary outputs have optional dead-time insertion. The block sits between the control loop, which writes duty words, and the gate-drive / motor-driver pins. It is the drop-in generalisation of the team's single-channel 11-bit PWM.

---
 rtl/pwm_multi.sv | 127 ++++++++++++
 1 files changed

// File: rtl/pwm_multi.sv
// Multi-channel edge-aligned PWM, shared counter, double-buffered duty; optional dead-time via PWM_DEADTIME_EN.
// Latency: outputs registered, one clock after cnt/active; duty change lands at the next period boundary.
// Backpressure: none; wr is always accepted and the last write before a boundary wins.
module pwm_multi #(
    parameter int         WIDTH    = 11,
    parameter int         CHANNELS = 2,
    parameter logic [7:0] DEADTIME = 8'd32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic [CHANNELS*WIDTH-1:0]    duty,
    input  logic                         wr,
    output logic [CHANNELS-1:0]          PWM_sig,
    output logic [CHANNELS-1:0]          PWM_sig_n,
    output logic                         prd_strt
);

    logic [WIDTH-1:0]                 cnt;
    logic [CHANNELS-1:0][WIDTH-1:0]   shadow;
    logic [CHANNELS-1:0][WIDTH-1:0]   active;
    logic                             pending;
    logic                             wrap;
    logic [CHANNELS-1:0]              tgt;

    assign wrap = en && (cnt == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + WIDTH'(1);
        end
    end

    // While disabled the period is parked at its start, so a write may go live at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow  <= '0;
            active  <= '0;
            pending <= 1'b0;
        end else begin
            if (wr) begin
                shadow <= duty;
            end
            if (wr && (wrap || !en)) begin
                active  <= duty;
                pending <= 1'b0;
            end else if (wr) begin
                pending <= 1'b1;
            end else if (wrap && pending) begin
                active  <= shadow;
                pending <= 1'b0;
            end
        end
    end

    always_comb begin
        tgt = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            tgt[i] = en && (cnt < active[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prd_strt <= 1'b0;
        end else begin
            prd_strt <= en && (cnt == '0);
        end
    end

`ifdef PWM_DEADTIME_EN
    localparam logic [7:0] DT_LOAD = DEADTIME - 8'd1;

    logic [CHANNELS-1:0]        tgt_q;
    logic [CHANNELS-1:0][7:0]   dt_cnt;

    // A dead band is only needed when the side being switched off was actually on;
    // if both sides are already low the new state can be driven immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PWM_sig   <= '0;
            PWM_sig_n <= '1;
            tgt_q     <= '0;
            dt_cnt    <= '0;
        end else begin
            tgt_q <= tgt;
            for (int i = 0; i < CHANNELS; i++) begin
                if (!en) begin
                    PWM_sig[i]   <= 1'b0;
                    PWM_sig_n[i] <= 1'b1;
                    dt_cnt[i]    <= '0;
                end else if (tgt[i] != tgt_q[i]) begin
                    if ((tgt[i] ? PWM_sig_n[i] : PWM_sig[i]) && (DEADTIME != 8'd0)) begin
                        PWM_sig[i]   <= 1'b0;
                        PWM_sig_n[i] <= 1'b0;
                        dt_cnt[i]    <= DT_LOAD;
                    end else begin
                        PWM_sig[i]   <= tgt[i];
                        PWM_sig_n[i] <= ~tgt[i];
                        dt_cnt[i]    <= '0;
                    end
                end else if (dt_cnt[i] != 8'd0) begin
                    dt_cnt[i] <= dt_cnt[i] - 8'd1;
                end else begin
                    PWM_sig[i]   <= tgt[i];
                    PWM_sig_n[i] <= ~tgt[i];
                end
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PWM_sig   <= '0;
            PWM_sig_n <= '1;
        end else begin
            PWM_sig   <= tgt;
            PWM_sig_n <= ~tgt;
        end
    end
`endif

endmodule
